// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared key debounce state encoding and 50 MHz timing defaults
package key_pkg;

   typedef enum logic [1:0] {
      ST_RELEASED     = 2'd0,
      ST_PRESS_WAIT   = 2'd1,
      ST_PRESSED      = 2'd2,
      ST_RELEASE_WAIT = 2'd3
   } key_state_t;

   localparam int DEF_DEBOUNCE_CYCLES = 500000;
   localparam int DEF_REPEAT_DELAY    = 25000000;
   localparam int DEF_REPEAT_PERIOD   = 5000000;

endpackage

// File: rtl/key_debounce_cell.sv
// rtl/key_debounce_cell.sv - one key: 2-flop sync, debounce FSM, press/release/repeat pulses
module key_debounce_cell
   import key_pkg::*;
#(
   parameter int ACTIVE_LOW      = 1,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_EN       = 0,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic clk,
   input  logic rst,
   input  logic key_raw,
   output logic keypress,
   output logic key_press,
   output logic key_release
);

   localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW   = $clog2(RMAX + 1);

   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);
   localparam logic          POL      = (ACTIVE_LOW != 0);
   localparam logic          REP_ON   = (REPEAT_EN != 0);

   logic          s0, s1;
   key_state_t    state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [RW-1:0] rcnt, rcnt_n;
   logic          rep, rep_n;
   logic          lvl_n, press_n, rel_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         s0          <= 1'b0;
         s1          <= 1'b0;
         state       <= ST_RELEASED;
         cnt         <= '0;
         rcnt        <= '0;
         rep         <= 1'b0;
         keypress    <= 1'b0;
         key_press   <= 1'b0;
         key_release <= 1'b0;
      end else begin
         s0          <= key_raw ^ POL;
         s1          <= s0;
         state       <= state_n;
         cnt         <= cnt_n;
         rcnt        <= rcnt_n;
         rep         <= rep_n;
         keypress    <= lvl_n;
         key_press   <= press_n;
         key_release <= rel_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      rcnt_n  = rcnt;
      rep_n   = rep;
      lvl_n   = keypress;
      press_n = 1'b0;
      rel_n   = 1'b0;
      case (state)
         ST_RELEASED: begin
            if (s1) begin
               state_n = ST_PRESS_WAIT;
               cnt_n   = '0;
            end
         end
         ST_PRESS_WAIT: begin
            if (!s1) begin
               state_n = ST_RELEASED;
               cnt_n   = '0;
            end else if (cnt == CNT_LAST) begin
               state_n = ST_PRESSED;
               cnt_n   = '0;
               rcnt_n  = '0;
               rep_n   = 1'b0;
               lvl_n   = 1'b1;
               press_n = 1'b1;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         ST_PRESSED: begin
            if (!s1) begin
               state_n = ST_RELEASE_WAIT;
               cnt_n   = '0;
            end else if (REP_ON) begin
               // first repeat waits the long delay, later ones the short period
               if (rcnt == (rep ? PER_LAST : DLY_LAST)) begin
                  press_n = 1'b1;
                  rcnt_n  = '0;
                  rep_n   = 1'b1;
               end else begin
                  rcnt_n = rcnt + 1'b1;
               end
            end
         end
         ST_RELEASE_WAIT: begin
            if (s1) begin
               state_n = ST_PRESSED;
               cnt_n   = '0;
               rcnt_n  = '0;
               rep_n   = 1'b0;
            end else if (cnt == CNT_LAST) begin
               state_n = ST_RELEASED;
               cnt_n   = '0;
               lvl_n   = 1'b0;
               rel_n   = 1'b1;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: begin
            state_n = ST_RELEASED;
            cnt_n   = '0;
         end
      endcase
   end

endmodule

// File: rtl/key_debouncer.sv
// rtl/key_debouncer.sv - N independent debounced keys for keypad display and game input
module key_debouncer
   import key_pkg::*;
#(
   parameter int N_KEYS          = 4,
   parameter int ACTIVE_LOW      = 1,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_EN       = 0,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_KEYS-1:0] keys_raw,
   output logic [N_KEYS-1:0] keypresses,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release
);

   for (genvar i = 0; i < N_KEYS; i++) begin : g_key
      key_debounce_cell #(
         .ACTIVE_LOW      (ACTIVE_LOW),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_EN       (REPEAT_EN),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_cell (
         .clk         (clk),
         .rst         (rst),
         .key_raw     (keys_raw[i]),
         .keypress    (keypresses[i]),
         .key_press   (key_press[i]),
         .key_release (key_release[i])
      );
   end

endmodule
